uart_tx_core: RTL

UART_TX_CORE -- requirements
Module: uart_tx_core

---
 rtl/uart_tx_core.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_core.sv
// UART transmitter: byte FIFO feeding an 8N1 serializer, BIT_TICKS clocks per bit.
// state | meaning
// IDLE  | line high, waiting for a queued byte
// START | start bit (low) for BIT_TICKS cycles
// DATA  | 8 data bits LSB first, BIT_TICKS cycles each
// STOP  | stop bit (high); pops the next byte at its end if one is queued
module uart_tx_core #(
  parameter int BIT_TICKS = 16,
  parameter int FIFO_AW   = 3
) (
  input  logic               clk_tf,
  input  logic               rst,
  input  logic [7:0]         tf_din,
  input  logic               tf_wr,
  output logic               tf_full,
  output logic               tf_empty,
  output logic [FIFO_AW:0]   tf_count,
  output logic               tf_ovf,
  output logic               tx_busy,
  output logic               transmitter_tx
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TW    = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
  localparam logic [TW-1:0]      TICK_LAST = TW'(BIT_TICKS - 1);
  localparam logic [TW-1:0]      TICK_ONE  = 1;
  localparam logic [FIFO_AW:0]   CNT_ONE   = 1;
  localparam logic [FIFO_AW:0]   CNT_FULL  = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW-1:0] PTR_ONE   = 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count_nxt;
  logic               wr_acc, pop;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          tick_last;

  // Acceptance uses the registered full flag, so a same-edge pop never frees a slot.
  assign wr_acc = tf_wr & ~tf_full;

  always_comb begin
    count_nxt = tf_count;
    if (wr_acc && !pop)      count_nxt = tf_count + CNT_ONE;
    else if (pop && !wr_acc) count_nxt = tf_count - CNT_ONE;
  end

  always_ff @(posedge clk_tf) begin
    if (wr_acc) mem[wr_ptr] <= tf_din;
  end

  always_ff @(posedge clk_tf or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      tf_count <= '0;
      tf_full  <= 1'b0;
      tf_empty <= 1'b1;
      tf_ovf   <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)    rd_ptr <= rd_ptr + PTR_ONE;
      tf_count <= count_nxt;
      tf_full  <= (count_nxt == CNT_FULL);
      tf_empty <= (count_nxt == '0);
      if (tf_wr && tf_full) tf_ovf <= 1'b1;
    end
  end

  assign tick_last = (tick_q == TICK_LAST);

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q + TICK_ONE;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        tick_d = '0;
        tx_d   = 1'b1;
        if (!tf_empty) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr];
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (tick_last) begin
          tick_d  = '0;
          bit_d   = 3'd0;
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (tick_last) begin
          tick_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end
      end
      STOP: begin
        if (tick_last) begin
          tick_d = '0;
          if (!tf_empty) begin
            pop     = 1'b1;
            shift_d = mem[rd_ptr];
            state_d = START;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tick_d  = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_tf or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign tx_busy        = (state_q != IDLE);
  assign transmitter_tx = tx_q;

endmodule
